wb_slave_decode: RTL and testbench

//  Wishbone B3 single-master to N-slave decoder: the slave-side counterpart of the multi-master bus mux.

---
 rtl/wb_slave_decode_pkg.sv | 29 ++
 rtl/wb_slave_decode_addr_decode.sv | 31 +++
 rtl/wb_slave_decode.sv | 202 ++++++++++++++++++++
 tb/tb_wb_slave_decode.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_slave_decode_pkg.sv
// Shared definitions for the Wishbone slave-side decoder.
//  - wb_dec_state_t : decoder FSM states
//  - CTI_*          : Wishbone B3 cycle type identifiers
//  - wdog_cnt_width : width of a counter that must be able to hold the timeout value
package wb_slave_decode_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        ERR    = 2'b10,
        ABORT  = 2'b11
    } wb_dec_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Never returns zero, so a disabled watchdog still gets a legal 1-bit counter.
    function automatic int wdog_cnt_width(input int timeout_cycles);
        int w;
        if (timeout_cycles < 1) begin
            w = 1;
        end else begin
            w = $clog2(timeout_cycles + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_slave_decode_addr_decode.sv
// wb_addr_decode: combinational address comparator array.
// Each slave i matches when the masked address equals its masked base.
// When several slaves match, only the lowest index is reported, so hit is
// one-hot or zero.
//  adr  in  ADDR_WIDTH  address to decode
//  hit  out SLAVES      one-hot slave select (zero when unmapped)
module wb_addr_decode #(
    parameter int                           SLAVES     = 3,
    parameter int                           ADDR_WIDTH = 32,
    parameter logic [SLAVES*ADDR_WIDTH-1:0] S_MATCH    = '0,
    parameter logic [SLAVES*ADDR_WIDTH-1:0] S_MASK     = '0
) (
    input  logic [ADDR_WIDTH-1:0] adr,
    output logic [SLAVES-1:0]     hit
);

    logic [SLAVES-1:0] raw_s;

    // Per-slave masked compare against its base address.
    always_comb begin
        raw_s = '0;
        for (int i = 0; i < SLAVES; i++) begin
            raw_s[i] = (((adr ^ S_MATCH[i*ADDR_WIDTH +: ADDR_WIDTH])
                        & S_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0);
        end
    end

    // Isolating the lowest set bit gives lowest-index priority.
    assign hit = raw_s & (~raw_s + SLAVES'(1));

endmodule

// File: rtl/wb_slave_decode.sv
// wb_slave_decode: Wishbone B3 single-master to N-slave decoder.
// The first strobe of a cycle is decoded and routed to the matching slave with
// no added latency; the selection is then held until the master drops cyc, so
// bursts and read-modify-write stay on one slave. Unmapped addresses and
// slaves that never answer are turned into a one-cycle bus error.
//  clk_i, rst_ni                      clock, synchronous active-low reset
//  m_*_i                              master request (adr/dat/cyc/stb/sel/we/cti/bte)
//  m_dat_o, m_ack_o, m_err_o, m_rty_o response to the master
//  s_adr_o..s_bte_o                   request broadcast to every slave
//  s_cyc_o, s_stb_o                   per-slave cycle/strobe, one-hot or zero
//  s_dat_i, s_ack_i, s_err_i, s_rty_i per-slave responses
//  err_unmapped_o, err_timeout_o      one-cycle error event pulses
module wb_slave_decode
    import wb_slave_decode_pkg::*;
#(
    parameter int                           SLAVES         = 3,
    parameter int                           DATA_WIDTH     = 32,
    parameter int                           ADDR_WIDTH     = 32,
    parameter logic [SLAVES*ADDR_WIDTH-1:0] S_MATCH        = '0,
    parameter logic [SLAVES*ADDR_WIDTH-1:0] S_MASK         = '0,
    parameter int                           TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [ADDR_WIDTH-1:0]        m_adr_i,
    input  logic [DATA_WIDTH-1:0]        m_dat_i,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    input  logic [DATA_WIDTH/8-1:0]      m_sel_i,
    input  logic                         m_we_i,
    input  logic [2:0]                   m_cti_i,
    input  logic [1:0]                   m_bte_i,
    output logic [DATA_WIDTH-1:0]        m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic                         m_rty_o,
    output logic [ADDR_WIDTH-1:0]        s_adr_o,
    output logic [DATA_WIDTH-1:0]        s_dat_o,
    output logic [DATA_WIDTH/8-1:0]      s_sel_o,
    output logic                         s_we_o,
    output logic [2:0]                   s_cti_o,
    output logic [1:0]                   s_bte_o,
    output logic [SLAVES-1:0]            s_cyc_o,
    output logic [SLAVES-1:0]            s_stb_o,
    input  logic [DATA_WIDTH*SLAVES-1:0] s_dat_i,
    input  logic [SLAVES-1:0]            s_ack_i,
    input  logic [SLAVES-1:0]            s_err_i,
    input  logic [SLAVES-1:0]            s_rty_i,
    output logic                         err_unmapped_o,
    output logic                         err_timeout_o
);

    localparam int               CNT_W     = wdog_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               WDOG_EN   = (TIMEOUT_CYCLES != 0);

    wb_dec_state_t          state_r, state_nxt_s;
    logic [SLAVES-1:0]      sel_r, sel_nxt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic                   err_unmapped_r, err_timeout_r;
    logic                   unmapped_set_s, timeout_set_s;
    logic [SLAVES-1:0]      hit_s;
    logic                   req_s, resp_s;
    logic [SLAVES-1:0]      s_cyc_s, s_stb_s;
    logic                   m_ack_s, m_err_s, m_rty_s;
    logic [DATA_WIDTH-1:0]  dat_mux_s, m_dat_s;

    wb_addr_decode #(
        .SLAVES     (SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .S_MATCH    (S_MATCH),
        .S_MASK     (S_MASK)
    ) u_addr_decode (
        .adr (m_adr_i),
        .hit (hit_s)
    );

    assign req_s  = m_cyc_i & m_stb_i;
    assign resp_s = |(sel_r & (s_ack_i | s_err_i | s_rty_i));

    // AND-OR read-data mux driven by the held selection.
    always_comb begin
        dat_mux_s = '0;
        for (int i = 0; i < SLAVES; i++) begin
            dat_mux_s = dat_mux_s
                      | (s_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_r[i]}});
        end
    end

    // Next-state, watchdog and per-state output decode.
    always_comb begin
        state_nxt_s    = state_r;
        sel_nxt_s      = sel_r;
        cnt_nxt_s      = cnt_r;
        unmapped_set_s = 1'b0;
        timeout_set_s  = 1'b0;
        s_cyc_s        = '0;
        s_stb_s        = '0;
        m_ack_s        = 1'b0;
        m_err_s        = 1'b0;
        m_rty_s        = 1'b0;
        m_dat_s        = '0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = '0;
                if (req_s) begin
                    if (|hit_s) begin
                        // First beat goes straight out; the selection is latched.
                        s_cyc_s     = hit_s;
                        s_stb_s     = hit_s;
                        sel_nxt_s   = hit_s;
                        state_nxt_s = ACTIVE;
                    end else begin
                        unmapped_set_s = 1'b1;
                        state_nxt_s    = ERR;
                    end
                end else begin
                    sel_nxt_s = '0;
                end
            end
            ACTIVE: begin
                s_cyc_s = sel_r & {SLAVES{m_cyc_i}};
                s_stb_s = sel_r & {SLAVES{m_stb_i}};
                m_ack_s = |(sel_r & s_ack_i);
                m_err_s = |(sel_r & s_err_i);
                m_rty_s = |(sel_r & s_rty_i);
                m_dat_s = dat_mux_s;
                if (!m_cyc_i) begin
                    state_nxt_s = IDLE;
                    sel_nxt_s   = '0;
                    cnt_nxt_s   = '0;
                end else if (resp_s || !m_stb_i || !WDOG_EN) begin
                    // A response in the limit cycle still wins over the watchdog.
                    cnt_nxt_s = '0;
                end else if (cnt_r == CNT_LIMIT) begin
                    // Counter already sits at the limit and still no answer.
                    state_nxt_s   = ABORT;
                    sel_nxt_s     = '0;
                    cnt_nxt_s     = '0;
                    timeout_set_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ERR: begin
                m_err_s     = 1'b1;
                state_nxt_s = IDLE;
            end
            ABORT: begin
                // Error only in the first abort cycle, marked by the timeout pulse.
                m_err_s = err_timeout_r;
                if (!m_cyc_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ABORT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                sel_nxt_s   = '0;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, selection, watchdog counter and event pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r        <= IDLE;
            sel_r          <= '0;
            cnt_r          <= '0;
            err_unmapped_r <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            sel_r          <= sel_nxt_s;
            cnt_r          <= cnt_nxt_s;
            err_unmapped_r <= unmapped_set_s;
            err_timeout_r  <= timeout_set_s;
        end
    end

    // Held reset silences both bus sides even if the master keeps requesting.
    assign s_cyc_o = s_cyc_s & {SLAVES{rst_ni}};
    assign s_stb_o = s_stb_s & {SLAVES{rst_ni}};
    assign m_ack_o = m_ack_s & rst_ni;
    assign m_err_o = m_err_s & rst_ni;
    assign m_rty_o = m_rty_s & rst_ni;
    assign m_dat_o = m_dat_s & {DATA_WIDTH{rst_ni}};

    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;
    assign s_cti_o = m_cti_i;
    assign s_bte_o = m_bte_i;

    assign err_unmapped_o = err_unmapped_r;
    assign err_timeout_o  = err_timeout_r;

endmodule

// File: tb/tb_wb_slave_decode.sv
// Self-checking bench for wb_slave_decode (3 slaves at 0x0/0x1/0x2 in the
// top nibble, watchdog limit 8). Every response the master should see is
// queued when the request is driven; a negedge monitor pops and compares
// each ack/err/rty the decoder produces.
module tb_wb_slave_decode;
    import wb_slave_decode_pkg::*;

    localparam int SLAVES = 3;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int TO     = 8;
    localparam logic [SLAVES*AW-1:0] MATCH = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [SLAVES*AW-1:0] MASK  = {3{32'hF000_0000}};

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] dat;
    } resp_t;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic [AW-1:0]        m_adr_i;
    logic [DW-1:0]        m_dat_i;
    logic                 m_cyc_i, m_stb_i, m_we_i;
    logic [DW/8-1:0]      m_sel_i;
    logic [2:0]           m_cti_i;
    logic [1:0]           m_bte_i;
    logic [DW-1:0]        m_dat_o;
    logic                 m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]        s_adr_o;
    logic [DW-1:0]        s_dat_o;
    logic [DW/8-1:0]      s_sel_o;
    logic                 s_we_o;
    logic [2:0]           s_cti_o;
    logic [1:0]           s_bte_o;
    logic [SLAVES-1:0]    s_cyc_o, s_stb_o;
    logic [DW*SLAVES-1:0] s_dat_i;
    logic [SLAVES-1:0]    s_ack_i, s_err_i, s_rty_i;
    logic                 err_unmapped_o, err_timeout_o;
    logic [DW-1:0]        sd [SLAVES];

    resp_t exp_q[$];
    resp_t mon_e;
    int    checks_cnt = 0;
    int    errors_cnt = 0;

    always #5 clk = ~clk;
    assign s_dat_i = {sd[2], sd[1], sd[0]};

    wb_slave_decode #(
        .SLAVES(SLAVES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .S_MATCH(MATCH), .S_MASK(MASK), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .err_unmapped_o(err_unmapped_o), .err_timeout_o(err_timeout_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic m_drive(input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [2:0] cti);
        m_cyc_i = cyc;
        m_stb_i = stb;
        m_we_i  = we;
        m_adr_i = adr;
        m_cti_i = cti;
    endtask

    // Scoreboard monitor: every master-visible response must be expected.
    always @(negedge clk) begin
        if (m_ack_o || m_err_o || m_rty_o) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {61'd0, m_ack_o, m_err_o, m_rty_o}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_resp", {29'd0, m_ack_o, m_err_o, m_rty_o, m_dat_o},
                      {29'd0, mon_e.ack, mon_e.err, mon_e.rty, mon_e.dat});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int  lat;
        bit  hold_ok;
        logic [2:0] exp_cti;

        rst_ni  = 1'b0;
        m_dat_i = 32'hDEAD_BEEF;
        m_sel_i = 4'hF;
        m_bte_i = 2'b00;
        s_ack_i = '0;
        s_err_i = '0;
        s_rty_i = '0;
        sd[0]   = 32'h1111_1111;
        sd[1]   = 32'h3333_3333;
        sd[2]   = 32'h2222_2222;
        // Master requests slave1 while reset is held: nothing may go out.
        m_drive(1'b1, 1'b1, 1'b0, 32'h1000_0000, CTI_CLASSIC);
        repeat (2) @(posedge clk);
        sample();
        check("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        check("rst_s_stb", 64'(s_stb_o), 64'd0);
        check("rst_resp", {61'd0, m_ack_o, m_err_o, m_rty_o}, 64'd0);
        check("rst_dat", 64'(m_dat_o), 64'd0);
        check("rst_state", 64'(dut.state_r), 64'(IDLE));

        // Idle responses are ignored.
        cycle_start();
        rst_ni = 1'b1;
        m_drive(1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        s_ack_i = 3'b111;
        sample();
        check("idle_ack_ignored", {29'd0, m_ack_o, m_err_o, m_rty_o, m_dat_o}, 64'd0);
        check("idle_s_cyc", 64'(s_cyc_o), 64'd0);

        // Read slave1, ack two cycles after the strobe.
        cycle_start();
        s_ack_i = '0;
        m_drive(1'b1, 1'b1, 1'b0, 32'h1000_0004, CTI_CLASSIC);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'hCAFE_F00D});
        sample();
        check("t1_s_cyc", 64'(s_cyc_o), 64'h2);
        check("t1_s_stb", 64'(s_stb_o), 64'h2);
        check("t1_s_adr", 64'(s_adr_o), 64'h1000_0004);
        cycle_start();
        s_ack_i = 3'b001;
        sample();
        check("t1_other_ack", 64'(m_ack_o), 64'd0);
        check("t1_hold", 64'(s_cyc_o), 64'h2);
        cycle_start();
        s_ack_i = 3'b010;
        sd[1]   = 32'hCAFE_F00D;
        sample();
        check("t1_ack", 64'(m_ack_o), 64'd1);
        check("t1_dat", 64'(m_dat_o), 64'hCAFE_F00D);
        cycle_start();
        s_ack_i = '0;
        m_drive(1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        sample();
        check("t1_drop", 64'(s_cyc_o), 64'd0);
        cycle_start();
        sample();
        check("t1_idle", 64'(dut.state_r), 64'(IDLE));

        // Four-beat incrementing burst on slave2.
        cycle_start();
        m_drive(1'b1, 1'b1, 1'b0, 32'h2000_0000, CTI_INCR);
        sample();
        check("t2_s_cyc0", 64'(s_cyc_o), 64'h4);
        for (int b = 0; b < 4; b++) begin
            cycle_start();
            exp_cti = (b == 3) ? CTI_EOB : CTI_INCR;
            m_drive(1'b1, 1'b1, 1'b0, 32'h2000_0000 + 32'(4 * b), exp_cti);
            s_ack_i = 3'b100;
            sd[2]   = 32'hB000_0000 + 32'(b);
            exp_q.push_back({1'b1, 1'b0, 1'b0, 32'hB000_0000 + 32'(b)});
            sample();
            check("t2_s_cyc", 64'(s_cyc_o), 64'h4);
            check("t2_ack", 64'(m_ack_o), 64'd1);
            check("t2_cti", 64'(s_cti_o), 64'(exp_cti));
        end
        cycle_start();
        s_ack_i = '0;
        sd[2]   = 32'h2222_2222;
        m_drive(1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        sample();
        check("t2_drop", 64'(s_cyc_o), 64'd0);
        cycle_start();
        sample();
        check("t2_idle", 64'(dut.state_r), 64'(IDLE));

        // Unmapped write.
        cycle_start();
        m_drive(1'b1, 1'b1, 1'b1, 32'h5000_0000, CTI_CLASSIC);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0});
        sample();
        check("t3_s_cyc", 64'(s_cyc_o), 64'd0);
        check("t3_s_stb", 64'(s_stb_o), 64'd0);
        check("t3_err_early", 64'(m_err_o), 64'd0);
        check("t3_bcast", {31'd0, s_we_o, s_dat_o}, {31'd0, 1'b1, 32'hDEAD_BEEF});
        cycle_start();
        sample();
        check("t3_err", {62'd0, m_err_o, err_unmapped_o}, 64'h3);
        check("t3_s_cyc_err", 64'(s_cyc_o), 64'd0);
        cycle_start();
        m_drive(1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        sample();
        check("t3_err_once", {62'd0, m_err_o, err_unmapped_o}, 64'd0);

        // Silent slave0: watchdog abort.
        cycle_start();
        m_drive(1'b1, 1'b1, 1'b0, 32'h0000_0010, CTI_CLASSIC);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0});
        sample();
        lat     = 0;
        hold_ok = 1'b1;
        while (!m_err_o && lat < 30) begin
            cycle_start();
            sample();
            lat++;
            if (!m_err_o && s_cyc_o != 3'b001) hold_ok = 1'b0;
        end
        // TO counting cycles, one more with the count at the limit, then the error.
        check("t4_latency", 64'(lat), 64'(TO + 2));
        check("t4_hold", 64'(hold_ok), 64'd1);
        check("t4_pulse", {62'd0, m_err_o, err_timeout_o}, 64'h3);
        check("t4_s_cyc", 64'(s_cyc_o), 64'd0);
        cycle_start();
        sample();
        check("t4_drain", {61'd0, m_err_o, err_timeout_o, |s_cyc_o}, 64'd0);
        check("t4_abort_state", 64'(dut.state_r), 64'(ABORT));
        cycle_start();
        m_drive(1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        cycle_start();
        sample();
        check("t4_idle", 64'(dut.state_r), 64'(IDLE));

        // Ack arrives exactly when the count sits at the limit.
        cycle_start();
        m_drive(1'b1, 1'b1, 1'b0, 32'h0000_0030, CTI_CLASSIC);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h5A5A_0000});
        repeat (TO) cycle_start();
        cycle_start();
        s_ack_i = 3'b001;
        sd[0]   = 32'h5A5A_0000;
        sample();
        check("t5_ack_wins", {62'd0, m_ack_o, m_err_o}, 64'h2);
        cycle_start();
        s_ack_i = '0;
        sd[0]   = 32'h1111_1111;
        m_drive(1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        sample();
        check("t5_no_timeout", {62'd0, m_err_o, err_timeout_o}, 64'd0);
        cycle_start();
        sample();
        check("t5_no_pulse", 64'(err_timeout_o), 64'd0);

        // Reset in the middle of a slave2 cycle.
        cycle_start();
        m_drive(1'b1, 1'b1, 1'b0, 32'h2000_0100, CTI_CLASSIC);
        cycle_start();
        sample();
        check("t6_active", 64'(s_cyc_o), 64'h4);
        cycle_start();
        rst_ni  = 1'b0;
        s_ack_i = 3'b100;
        cycle_start();
        sample();
        check("t6_s_cyc", 64'(s_cyc_o), 64'd0);
        check("t6_resp", {29'd0, m_ack_o, m_err_o, m_rty_o, m_dat_o}, 64'd0);
        check("t6_state", 64'(dut.state_r), 64'(IDLE));
        cycle_start();
        rst_ni  = 1'b1;
        s_ack_i = '0;
        m_drive(1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        sample();
        check("t6_after", 64'(s_cyc_o), 64'd0);

        // Retry forwarded from slave0.
        cycle_start();
        m_drive(1'b1, 1'b1, 1'b0, 32'h0000_0020, CTI_CLASSIC);
        exp_q.push_back({1'b0, 1'b0, 1'b1, 32'h1111_1111});
        cycle_start();
        s_rty_i = 3'b001;
        sample();
        check("t7_rty", 64'(m_rty_o), 64'd1);
        cycle_start();
        s_rty_i = '0;
        m_drive(1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        repeat (2) cycle_start();
        sample();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
